// File: rtl/tl_pkg.sv
// Shared definitions for the traffic-light phase scheduler.
// Holds the controller state encoding, the lamp patterns and two pure
// helper functions used by the top level: the grant arbiter and the
// per-approach lamp decode.  Lamp patterns are written MSB-first as
// {red, yellow, green}.
package tl_pkg;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_ALLRED = 3'd1,
        ST_GREEN  = 3'd2,
        ST_YELLOW = 3'd3,
        ST_FLASH  = 3'd4
    } state_t;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;
    localparam logic [2:0] OFF = 3'b000;

    // Priority demand wins at the lowest index; otherwise rotate from last+1.
    function automatic logic [1:0] arb_pick(input logic [3:0] elig,
                                            input logic [3:0] pref_elig,
                                            input logic [1:0] last);
        logic [1:0] pick;
        logic [1:0] idx;
        logic       found;
        pick  = 2'd0;
        found = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            if (pref_elig[k]) begin
                pick  = 2'(k);
                found = 1'b1;
            end else begin
                pick = pick;
            end
        end
        for (int k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (!found && elig[idx]) begin
                pick  = idx;
                found = 1'b1;
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

    // Lamp pattern shown on approach idx for a given controller state.
    function automatic logic [2:0] lamp_of(input state_t st, input logic [1:0] grant,
                                           input logic [1:0] idx, input logic flash_on);
        logic [2:0] lamp;
        case (st)
            ST_INIT:   lamp = OFF;
            ST_ALLRED: lamp = RED;
            ST_GREEN:  lamp = (idx == grant) ? GRN : RED;
            ST_YELLOW: lamp = (idx == grant) ? YEL : RED;
            ST_FLASH:  lamp = flash_on ? YEL : OFF;
            default:   lamp = RED;
        endcase
        return lamp;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// 8-bit loadable down-counter used to time every phase and flash half-period.
// Ports: clk, rst (sync, active-low), i_load/i_value load a new count,
// o_count is the current count, o_zero flags a count of zero.
// The counter holds at zero until reloaded.
module phase_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic [7:0] i_value,
    output logic [7:0] o_count,
    output logic       o_zero
);

    logic [7:0] r_count;

    // Count register: load has priority over decrement.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= 8'd0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != 8'd0) begin
            r_count <= r_count - 8'd1;
        end else begin
            r_count <= r_count;
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == 8'd0);

endmodule

// File: rtl/phase_scheduler.sv
// Four-approach traffic-light phase scheduler.
// Ports: clk; rst (sync, active-low); attention forces flashing yellow;
// requests/preferentials are normal/priority demand per approach;
// force_reds pins approaches red; ltfs are the registered lamps per
// approach ({red,yellow,green}); grant_idx/grant_valid name the approach
// in green or yellow.
// A single phase_timer times every phase; in FLASH it times half-periods.
// Outputs are registered from the next-state values so they line up with
// the state register.
module phase_scheduler
    import tl_pkg::*;
#(
    parameter int GREEN_CYCLES  = 8,
    parameter int MIN_GREEN     = 3,
    parameter int YELLOW_CYCLES = 2,
    parameter int ALLRED_CYCLES = 2,
    parameter int FLASH_CYCLES  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            attention,
    input  logic [3:0]      requests,
    input  logic [3:0]      preferentials,
    input  logic [3:0]      force_reds,
    output logic [3:0][0:2] ltfs,
    output logic [1:0]      grant_idx,
    output logic            grant_valid
);

    localparam logic [7:0] LD_GREEN  = 8'(GREEN_CYCLES - 1);
    localparam logic [7:0] LD_YELLOW = 8'(YELLOW_CYCLES - 1);
    localparam logic [7:0] LD_ALLRED = 8'(ALLRED_CYCLES - 1);
    localparam logic [7:0] LD_FLASH  = 8'(FLASH_CYCLES - 1);
    // Remaining count at or below this means MIN_GREEN cycles have been shown.
    localparam logic [7:0] LIM_PREEMPT = 8'(GREEN_CYCLES - MIN_GREEN);

    state_t          r_state;
    state_t          w_next_state;
    logic [1:0]      r_grant;
    logic [1:0]      w_next_grant;
    logic [1:0]      r_last;
    logic [1:0]      w_next_last;
    logic            r_flash_on;
    logic            w_next_flash_on;
    logic            r_gv;
    logic [3:0][0:2] r_ltfs;
    logic            w_load;
    logic [7:0]      w_load_val;
    logic [7:0]      w_count;
    logic            w_zero;
    logic [3:0]      w_elig;
    logic [3:0]      w_pref_elig;
    logic [3:0]      w_rivals;
    logic [1:0]      w_pick;
    logic            w_preempt;
    logic            w_force_cur;

    phase_timer u_timer (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_value (w_load_val),
        .o_count (w_count),
        .o_zero  (w_zero)
    );

    assign w_elig      = (requests | preferentials) & ~force_reds;
    assign w_pref_elig = preferentials & ~force_reds;
    assign w_pick      = arb_pick(w_elig, w_pref_elig, r_last);
    assign w_rivals    = w_pref_elig & ~(4'b0001 << r_grant);
    assign w_preempt   = (|w_rivals) && (w_count <= LIM_PREEMPT);
    assign w_force_cur = force_reds[r_grant];

    // Next-state, timer reload and grant bookkeeping.
    always_comb begin
        w_next_state    = r_state;
        w_next_grant    = r_grant;
        w_next_last     = r_last;
        w_next_flash_on = r_flash_on;
        w_load          = 1'b0;
        w_load_val      = 8'd0;
        if (r_state == ST_INIT) begin
            w_next_state = ST_ALLRED;
            w_load       = 1'b1;
            w_load_val   = LD_ALLRED;
        end else if (attention && (r_state != ST_FLASH)) begin
            // Attention pre-empts everything, including a same-cycle expiry.
            w_next_state    = ST_FLASH;
            w_load          = 1'b1;
            w_load_val      = LD_FLASH;
            w_next_flash_on = 1'b1;
        end else begin
            case (r_state)
                ST_ALLRED: begin
                    // At zero the timer holds, so arbitration repeats each cycle.
                    if (w_zero && (|w_elig)) begin
                        w_next_state = ST_GREEN;
                        w_next_grant = w_pick;
                        w_load       = 1'b1;
                        w_load_val   = LD_GREEN;
                    end else begin
                        w_next_state = ST_ALLRED;
                    end
                end
                ST_GREEN: begin
                    // Force-red, preemption and expiry all share one yellow.
                    if (w_force_cur || w_preempt || w_zero) begin
                        w_next_state = ST_YELLOW;
                        w_next_last  = r_grant;
                        w_load       = 1'b1;
                        w_load_val   = LD_YELLOW;
                    end else begin
                        w_next_state = ST_GREEN;
                    end
                end
                ST_YELLOW: begin
                    if (w_zero) begin
                        w_next_state = ST_ALLRED;
                        w_load       = 1'b1;
                        w_load_val   = LD_ALLRED;
                    end else begin
                        w_next_state = ST_YELLOW;
                    end
                end
                ST_FLASH: begin
                    if (!attention) begin
                        w_next_state = ST_ALLRED;
                        w_load       = 1'b1;
                        w_load_val   = LD_ALLRED;
                    end else if (w_zero) begin
                        w_next_flash_on = ~r_flash_on;
                        w_load          = 1'b1;
                        w_load_val      = LD_FLASH;
                    end else begin
                        w_next_flash_on = r_flash_on;
                    end
                end
                default: begin
                    w_next_state = ST_ALLRED;
                    w_load       = 1'b1;
                    w_load_val   = LD_ALLRED;
                end
            endcase
        end
    end

    // State, grant and registered lamp outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_INIT;
            r_grant    <= 2'd0;
            r_last     <= 2'd3;
            r_flash_on <= 1'b0;
            r_gv       <= 1'b0;
            r_ltfs     <= '0;
        end else begin
            r_state    <= w_next_state;
            r_grant    <= w_next_grant;
            r_last     <= w_next_last;
            r_flash_on <= w_next_flash_on;
            r_gv       <= (w_next_state == ST_GREEN) || (w_next_state == ST_YELLOW);
            for (int i = 0; i < 4; i++) begin
                r_ltfs[i] <= lamp_of(w_next_state, w_next_grant, 2'(i), w_next_flash_on);
            end
        end
    end

    assign ltfs        = r_ltfs;
    assign grant_idx   = r_grant;
    assign grant_valid = r_gv;

endmodule

// File: tb/tb_phase_scheduler.sv
// Self-checking bench for phase_scheduler: a phase-age reference model
// checked every cycle, directed scenarios with hand-computed expectations,
// then randomized stimulus.
module tb_phase_scheduler;

    localparam int G  = 8;
    localparam int MG = 3;
    localparam int Y  = 2;
    localparam int AR = 2;
    localparam int FL = 2;

    logic            clk;
    logic            rst;
    logic            attention;
    logic [3:0]      requests;
    logic [3:0]      preferentials;
    logic [3:0]      force_reds;
    logic [3:0][0:2] ltfs;
    logic [1:0]      grant_idx;
    logic            grant_valid;

    int n_vec = 0;
    int n_err = 0;

    phase_scheduler #(
        .GREEN_CYCLES(G), .MIN_GREEN(MG), .YELLOW_CYCLES(Y),
        .ALLRED_CYCLES(AR), .FLASH_CYCLES(FL)
    ) dut (
        .clk(clk), .rst(rst), .attention(attention), .requests(requests),
        .preferentials(preferentials), .force_reds(force_reds),
        .ltfs(ltfs), .grant_idx(grant_idx), .grant_valid(grant_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // mode: 0 INIT, 1 ALLRED, 2 GREEN, 3 YELLOW, 4 FLASH; age counts the
    // cycles already shown in the current mode (1 on entry).
    int m_mode  = 0;
    int m_age   = 1;
    int m_grant = 0;
    int m_last  = 3;
    bit m_valid = 1'b0;

    always @(posedge clk) begin
        int cand;
        int j;
        bit rival;
        if (!rst) begin
            m_mode = 0; m_age = 1; m_grant = 0; m_last = 3; m_valid = 1'b1;
        end else if (m_valid) begin
            if (m_mode == 0) begin
                m_mode = 1; m_age = 1;
            end else if (attention && m_mode != 4) begin
                m_mode = 4; m_age = 1;
            end else if (m_mode == 4) begin
                if (!attention) begin m_mode = 1; m_age = 1; end
                else m_age++;
            end else if (m_mode == 1) begin
                cand = -1;
                for (int i = 0; i < 4; i++)
                    if (cand < 0 && preferentials[i] && !force_reds[i]) cand = i;
                for (int k = 1; k <= 4; k++) begin
                    j = (m_last + k) % 4;
                    if (cand < 0 && (requests[j] || preferentials[j]) && !force_reds[j]) cand = j;
                end
                if (m_age >= AR && cand >= 0) begin
                    m_grant = cand; m_mode = 2; m_age = 1;
                end else m_age++;
            end else if (m_mode == 2) begin
                rival = 1'b0;
                for (int i = 0; i < 4; i++)
                    if (i != m_grant && preferentials[i] && !force_reds[i]) rival = 1'b1;
                if (force_reds[m_grant] || (rival && m_age >= MG) || m_age >= G) begin
                    m_last = m_grant; m_mode = 3; m_age = 1;
                end else m_age++;
            end else begin
                if (m_age >= Y) begin m_mode = 1; m_age = 1; end
                else m_age++;
            end
        end
    end

    // Compare process: DUT outputs against the model, every cycle.
    always @(negedge clk) begin
        logic [11:0] e;
        logic [2:0]  l;
        if (m_valid) begin
            for (int i = 0; i < 4; i++) begin
                case (m_mode)
                    0: l = 3'b000;
                    1: l = 3'b100;
                    2: l = (i == m_grant) ? 3'b001 : 3'b100;
                    3: l = (i == m_grant) ? 3'b010 : 3'b100;
                    default: l = (((m_age - 1) / FL) % 2 == 0) ? 3'b010 : 3'b000;
                endcase
                e[i*3 +: 3] = l;
            end
            chk("model_ltfs", {20'd0, ltfs}, {20'd0, e});
            chk("model_valid", {31'd0, grant_valid}, (m_mode == 2 || m_mode == 3) ? 32'd1 : 32'd0);
            if (m_mode == 2 || m_mode == 3)
                chk("model_grant", {30'd0, grant_idx}, 32'(m_grant));
        end
    end

    // ---------------- directed + random stimulus ----------------
    function automatic logic [2:0] exp_a(input int k);
        if (k == 0) return 3'b000;
        else if (k <= 2) return 3'b100;
        else if (k <= 10) return 3'b001;
        else if (k <= 12) return 3'b010;
        else return 3'b100;
    endfunction

    // Called at the INIT cycle with rst just released and requests=0001.
    task automatic run_seq_a();
        for (int k = 0; k <= 14; k++) begin
            chk("seqA_lamp0", {29'd0, ltfs[0]}, {29'd0, exp_a(k)});
            chk("seqA_valid", {31'd0, grant_valid}, (k >= 3 && k <= 12) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        chk("seqA_regrant", {29'd0, ltfs[0]}, 32'h1);
    endtask

    initial begin
        int order[5];
        int ng;
        bit found;
        bit prev_gv;
        order = '{0, 1, 2, 3, 0};
        rst = 1'b0; attention = 1'bx; requests = 'x; preferentials = 'x; force_reds = 'x;
        repeat (3) @(negedge clk);
        chk("rst_ltfs", {20'd0, ltfs}, 32'h0);
        chk("rst_valid", {31'd0, grant_valid}, 32'd0);
        chk("rst_idx", {30'd0, grant_idx}, 32'd0);
        rst = 1'b1; attention = 1'b0; requests = 4'b0001;
        preferentials = 4'b0000; force_reds = 4'b0000;
        run_seq_a();

        // Priority demand during green cycle 1 of approach 0.
        preferentials = 4'b0100;
        repeat (2) @(negedge clk);
        chk("pre_green3", {29'd0, ltfs[0]}, 32'h1);
        @(negedge clk);
        chk("pre_yellow", {29'd0, ltfs[0]}, 32'h2);
        repeat (4) @(negedge clk);
        chk("pre_grant2_lamp", {29'd0, ltfs[2]}, 32'h1);
        chk("pre_grant2_idx", {30'd0, grant_idx}, 32'd2);
        preferentials = 4'b0000; requests = 4'b0000;

        // Attention raised during yellow.
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            if (ltfs[2] == 3'b010) found = 1'b1;
        end
        chk("wait_yellow", {31'd0, found}, 32'd1);
        attention = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("flash", {20'd0, ltfs}, (k % 4 < 2) ? 32'h492 : 32'h000);
        end
        attention = 1'b0; requests = 4'b0010;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("flash_exit_red", {20'd0, ltfs}, 32'h924);
        end
        @(negedge clk);
        chk("post_flash_grant", {29'd0, ltfs[1]}, 32'h1);

        // Force-red of approach 1 at its green cycle 5.
        repeat (4) @(negedge clk);
        force_reds = 4'b0010;
        @(negedge clk);
        chk("force_yellow", {29'd0, ltfs[1]}, 32'h2);
        repeat (20) @(negedge clk);
        chk("forced_stays_red", {29'd0, ltfs[1]}, 32'h4);

        // Reset in the middle of a green.
        force_reds = 4'b0000; requests = 4'b0001;
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            if (ltfs[0] == 3'b001) found = 1'b1;
        end
        chk("wait_green0", {31'd0, found}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_ltfs", {20'd0, ltfs}, 32'h0);
        chk("midrst_valid", {31'd0, grant_valid}, 32'd0);
        rst = 1'b1;
        run_seq_a();

        // Round-robin over all four approaches from reset.
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1; requests = 4'b1111;
        ng = 0; prev_gv = 1'b0;
        for (int c = 0; c < 100 && ng < 5; c++) begin
            @(negedge clk);
            if (grant_valid && !prev_gv) begin
                chk("rr_order", {30'd0, grant_idx}, 32'(order[ng]));
                ng++;
            end
            prev_gv = grant_valid;
        end
        chk("rr_count", 32'(ng), 32'd5);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 59) == 0) attention = ~attention;
            requests = 4'($urandom);
            preferentials = 4'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 9) == 0) force_reds = 4'($urandom & $urandom);
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/phase_scheduler.md
PHASE_SCHEDULER -- requirements
Module: phase_scheduler

Interface
REQ-001 Parameter GREEN_CYCLES, default 8, is the full green duration in clock cycles (1..255).
REQ-002 Parameter MIN_GREEN, default 3, is the minimum green time before a preferential preemption (1..GREEN_CYCLES).
REQ-003 Parameters YELLOW_CYCLES (default 2), ALLRED_CYCLES (default 2) and FLASH_CYCLES (default 2) set phase and flash half-period durations in cycles (1..255).
REQ-004 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1: reset, synchronous and active-low.
REQ-006 Port attention, input, 1: 1 requests flashing-yellow mode on all approaches.
REQ-007 Port requests, input, 4: bit i is normal demand on approach i.
REQ-008 Port preferentials, input, 4: bit i is priority demand on approach i.
REQ-009 Port force_reds, input, 4: bit i pins approach i red and makes it ineligible for grant.
REQ-010 Port ltfs, output, [3:0][0:2]: per-approach lamps, bit 0 red, bit 1 yellow, bit 2 green, registered.
REQ-011 Port grant_idx, output, 2: approach currently in green or yellow; grant_valid, output, 1: high in GREEN and YELLOW only.

Function
REQ-012 FSM states: INIT, ALLRED, GREEN, YELLOW, FLASH; each timed state lasts exactly its parameter count in cycles (timer loaded with N-1 on entry, exits on zero).
REQ-013 INIT: all ltfs 3'b000; on the first cycle after reset release, go to ALLRED.
REQ-014 ALLRED: every ltfs 3'b100; on timer expiry, arbitrate; if no eligible approach, remain in ALLRED and re-arbitrate every cycle.
REQ-015 Eligibility: eligible = (requests | preferentials) & ~force_reds, sampled in the arbitration cycle.
REQ-016 Arbitration: if any eligible bit is preferential, grant the lowest-index one; otherwise grant round-robin, starting at last_grant+1 mod 4; last_grant resets to 3.
REQ-017 GREEN: the granted approach is 3'b001 and the others 3'b100; exit to YELLOW on timer expiry.
REQ-018 GREEN early exit: if force_reds[grant_idx] rises, go to YELLOW on the next edge regardless of elapsed time.
REQ-019 GREEN preemption: if another approach has preferential & ~force_reds and at least MIN_GREEN cycles have elapsed, go to YELLOW on the next edge.
REQ-020 YELLOW: the granted approach is 3'b010 and the others 3'b100; go to ALLRED on expiry; last_grant updates on YELLOW entry.
REQ-021 Attention: attention=1 in any non-INIT state moves to FLASH on the next edge; it overrides all other inputs.
REQ-022 FLASH: all four ltfs alternate 3'b010 and 3'b000, FLASH_CYCLES each, starting with 3'b010; force_reds is ignored.
REQ-023 FLASH exit: attention=0 goes to ALLRED with a full ALLRED_CYCLES timer.
REQ-024 Safety invariant: at most one approach is non-red outside FLASH and INIT; no green follows another green without intervening YELLOW and ALLRED.
REQ-025 Simultaneous expiry and attention: attention wins.
REQ-026 Simultaneous preemption and force_red of the current grant: a single YELLOW phase results.

Reset
REQ-027 rst=0 sampled at a rising edge: state INIT, ltfs all 3'b000, grant_valid 0, grant_idx 0, last_grant 3, and timers cleared.
REQ-028 Reset asserted mid-phase, including FLASH, takes effect on that edge with no yellow clearance.
REQ-029 While rst=0, all other inputs are ignored, including X values.

Structure
REQ-030 Package tl_pkg holds the state enum and the lamp constants RED=3'b100, YEL=3'b010, GRN=3'b001 and OFF=3'b000.
REQ-031 Sub-module phase_timer is an 8-bit loadable down-counter with load, value and zero flag, instantiated for phase and flash timing.

Verification
REQ-032 Reset then requests=4'b0001 with defaults -> INIT 1 cycle, ALLRED 2 cycles, ltfs[0]=001 for 8 cycles, 010 for 2 cycles, then all 100.
REQ-033 requests=4'b1111 held -> grants in order 0,1,2,3,0, with each green 8 cycles, separated by 2 yellow and 2 all-red cycles.
REQ-034 Approach 0 green, preferentials=4'b0100 at green cycle 1 -> yellow begins after cycle 3, then ALLRED, then approach 2 green.
REQ-035 Approach 1 green, force_reds=4'b0010 at green cycle 5 -> next cycle ltfs[1]=010; approach 1 is never granted while forced.
REQ-036 attention=1 during YELLOW -> next edge all ltfs 010, then 000 alternating every 2 cycles; attention=0 -> 2 cycles of all 100, then arbitration.
REQ-037 rst=0 mid-GREEN -> next edge all ltfs 000 and grant_valid=0; after release the sequence matches REQ-032.
